dec_syndrome_stage: RTL and testbench



---
 rtl/ecc_pkg.sv | 96 +++++++++
 rtl/dec_syndrome_stage_col_match.sv | 33 +++
 rtl/dec_syndrome_stage.sv | 129 ++++++++++++
 tb/tb_dec_syndrome_stage.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// ecc_pkg: definitions shared by the ECC encoder and the decoder syndrome stage.
// Holds the mode encoding, per-mode widths, the three H matrices, matrix and
// mask helpers, and the decoder FSM state type.
package ecc_pkg;

    localparam int MAX_CW_W = 32;
    localparam int MAX_P_W  = 6;

    typedef enum logic [1:0] {
        MOD_8       = 2'd0,
        MOD_16      = 2'd1,
        MOD_32      = 2'd2,
        MOD_ILLEGAL = 2'd3
    } mod_e;

    localparam int INFO_W_8  = 4;
    localparam int PAR_W_8   = 4;
    localparam int INFO_W_16 = 11;
    localparam int PAR_W_16  = 5;
    localparam int INFO_W_32 = 26;
    localparam int PAR_W_32  = 6;

    // Row P-1 of each matrix is the overall-parity row (all ones).
    localparam logic [3:0][7:0]  H1 = 32'hffe4_d2b1;
    localparam logic [4:0][15:0] H2 = 80'hffff_fe08_f1c4_cda2_ab61;
    localparam logic [5:0][31:0] H3 =
        192'hffff_ffff_fffe_0010_ff01_fc08_f0f1_e384_cccd_9b42_aaab_56c1;

    // Any mode's H zero-padded to the largest shape: rows >= P and columns
    // >= width are zero, so they never contribute to a syndrome or a match.
    typedef logic [MAX_P_W-1:0][MAX_CW_W-1:0] hmat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_CORRECT,
        ST_DONE
    } state_e;

    function automatic logic [2:0] parity_width(input logic [1:0] m);
        case (m)
            MOD_8:   return 3'(PAR_W_8);
            MOD_16:  return 3'(PAR_W_16);
            MOD_32:  return 3'(PAR_W_32);
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [5:0] cw_width(input logic [1:0] m);
        case (m)
            MOD_8:   return 6'd8;
            MOD_16:  return 6'd16;
            MOD_32:  return 6'd32;
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [MAX_CW_W-1:0] cw_mask(input logic [1:0] m);
        case (m)
            MOD_8:   return 32'h0000_00ff;
            MOD_16:  return 32'h0000_ffff;
            MOD_32:  return 32'hffff_ffff;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // One-hot position of the overall-parity row inside the syndrome.
    function automatic logic [MAX_P_W-1:0] par_bit_mask(input logic [1:0] m);
        case (m)
            MOD_8:   return 6'h08;
            MOD_16:  return 6'h10;
            MOD_32:  return 6'h20;
            default: return 6'h00;
        endcase
    endfunction

    function automatic hmat_t h_matrix(input logic [1:0] m);
        hmat_t h;
        h = '0;
        case (m)
            MOD_8:   for (int r = 0; r < PAR_W_8; r++)  h[r][7:0]  = H1[r];
            MOD_16:  for (int r = 0; r < PAR_W_16; r++) h[r][15:0] = H2[r];
            MOD_32:  h = H3;
            default: h = '0;
        endcase
        return h;
    endfunction

    function automatic logic [MAX_P_W-1:0] h_column(input hmat_t h, input int j);
        logic [MAX_P_W-1:0] col;
        col = '0;
        for (int r = 0; r < MAX_P_W; r++) col[r] = h[r][j];
        return col;
    endfunction

endpackage

// File: rtl/dec_syndrome_stage_col_match.sv
// syn_col_match: combinational search for the H column equal to a syndrome.
//   i_syn   syndrome, zero above the mode's parity count
//   i_mod   codeword mode
//   i_h     mode's H matrix, zero-padded
//   o_flip  one-hot mask of the matching column (lowest index wins)
//   o_match a column inside the mode width matched
module syn_col_match
    import ecc_pkg::*;
(
    input  logic [MAX_P_W-1:0]  i_syn,
    input  logic [1:0]          i_mod,
    input  hmat_t               i_h,
    output logic [MAX_CW_W-1:0] o_flip,
    output logic                o_match
);

    logic [5:0] w_width;
    assign w_width = cw_width(i_mod);

    always_comb begin
        o_flip  = '0;
        o_match = 1'b0;
        // Scan downward so a lower-index match overwrites a higher one.
        for (int j = MAX_CW_W-1; j >= 0; j--) begin
            if (j < int'(w_width) && h_column(i_h, j) == i_syn) begin
                o_flip    = '0;
                o_flip[j] = 1'b1;
                o_match   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dec_syndrome_stage.sv
// dec_syndrome_stage: SEC-DED decoder stage. Accepts a codeword (8/16/32-bit
// mode), builds its syndrome one H row per clock, then corrects a single-bit
// error or flags an uncorrectable one.
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready        input handshake; in_ready high only in IDLE
//   data_in, mod             received codeword and mode (3 = illegal)
//   out_valid/out_ready      output handshake; results hold until accepted
//   data_out                 corrected codeword, zero above the mode width
//   syndrome                 raw syndrome, bit P-1 is overall parity
//   num_of_errors            0 none, 1 corrected, 2 uncorrectable, 3 illegal mod
module dec_syndrome_stage
    import ecc_pkg::*;
#(
    parameter int MAX_CODEWORD_WIDTH = 32,
    parameter int MAX_PARITY_WIDTH   = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
    input  logic [1:0]                    mod,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
    output logic [MAX_PARITY_WIDTH-1:0]   syndrome,
    output logic [1:0]                    num_of_errors
);

    state_e                  r_state, w_state_nxt;
    logic [1:0]              r_mod;
    logic [MAX_CW_W-1:0]     r_cw;
    logic [MAX_P_W-1:0]      r_syn;
    logic [2:0]              r_row;
    logic [MAX_CW_W-1:0]     r_data_out;
    logic [MAX_P_W-1:0]      r_syn_out;
    logic [1:0]              r_nerr;
    logic                    r_out_valid;

    hmat_t                   w_h;
    logic [MAX_CW_W-1:0]     w_flip;
    logic                    w_match;
    logic                    w_p;
    logic [2:0]              w_pw_in;

    assign w_h     = h_matrix(r_mod);
    assign w_p     = |(r_syn & par_bit_mask(r_mod));
    assign w_pw_in = parity_width(mod);

    syn_col_match u_col_match (
        .i_syn   (r_syn),
        .i_mod   (r_mod),
        .i_h     (w_h),
        .o_flip  (w_flip),
        .o_match (w_match)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (in_valid) w_state_nxt = (mod == MOD_ILLEGAL) ? ST_CORRECT : ST_CALC;
            ST_CALC:    if (r_row == 3'd0) w_state_nxt = ST_CORRECT;
            ST_CORRECT: w_state_nxt = ST_DONE;
            ST_DONE:    if (out_ready) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mod       <= '0;
            r_cw        <= '0;
            r_syn       <= '0;
            r_row       <= '0;
            r_data_out  <= '0;
            r_syn_out   <= '0;
            r_nerr      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_mod <= mod;
                    r_cw  <= data_in & cw_mask(mod);
                    r_syn <= '0;
                    r_row <= (w_pw_in == 3'd0) ? 3'd0 : w_pw_in - 3'd1;
                end
                ST_CALC: begin
                    r_syn[r_row] <= ^(w_h[r_row] & r_cw);
                    if (r_row != 3'd0) r_row <= r_row - 3'd1;
                end
                ST_CORRECT: begin
                    r_out_valid <= 1'b1;
                    if (r_mod == MOD_ILLEGAL) begin
                        r_data_out <= '0;
                        r_syn_out  <= '0;
                        r_nerr     <= 2'd3;
                    end else if (r_syn == '0) begin
                        r_data_out <= r_cw;
                        r_syn_out  <= r_syn;
                        r_nerr     <= 2'd0;
                    end else if (w_p && w_match) begin
                        r_data_out <= r_cw ^ w_flip;
                        r_syn_out  <= r_syn;
                        r_nerr     <= 2'd1;
                    end else begin
                        // Even-weight error, or odd weight with no matching column.
                        r_data_out <= r_cw;
                        r_syn_out  <= r_syn;
                        r_nerr     <= 2'd2;
                    end
                end
                ST_DONE: if (out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign in_ready      = (r_state == ST_IDLE);
    assign out_valid     = r_out_valid;
    assign data_out      = r_data_out;
    assign syndrome      = r_syn_out;
    assign num_of_errors = r_nerr;

endmodule

// File: tb/tb_dec_syndrome_stage.sv
module tb_dec_syndrome_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] data_in = '0;
    logic [1:0]  mod = '0;
    logic        in_ready, out_valid;
    logic [31:0] data_out;
    logic [5:0]  syndrome;
    logic [1:0]  num_of_errors;

    dec_syndrome_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_in       (data_in),
        .mod           (mod),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_out      (data_out),
        .syndrome      (syndrome),
        .num_of_errors (num_of_errors)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  syn;
        logic [1:0]  nerr;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one word for exactly one accepting edge and record what it should yield.
    task automatic send(input logic [1:0] m, input logic [31:0] d, input logic [31:0] ed,
                        input logic [5:0] es, input logic [1:0] en, input int el);
        exp_t e;
        e.data = ed; e.syn = es; e.nerr = en; e.lat = el;
        sb.push_back(e);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        mod      = m;
        data_in  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_in  = '0;
    endtask

    // Wait for the result, compare it, optionally stall the consumer, then accept it.
    task automatic collect(input int hold);
        exp_t e;
        int   lat;
        e   = sb.pop_front();
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 20);
        check("latency", 32'(lat), 32'(e.lat));
        check("data_out", data_out, e.data);
        check("syndrome", 32'(syndrome), 32'(e.syn));
        check("num_of_errors", 32'(num_of_errors), 32'(e.nerr));
        check("in_ready_busy", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            mod      = 2'd0;
            data_in  = 32'h0000_0030;
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", data_out, e.data);
            check("hold_syn", 32'(syndrome), 32'(e.syn));
            check("hold_nerr", 32'(num_of_errors), 32'(e.nerr));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        data_in  = '0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_syndrome", 32'(syndrome), 32'd0);
        check("rst_nerr", 32'(num_of_errors), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 8-bit mode: clean word, single errors, double error
        send(2'd0, 32'h0000_0000, 32'h0000_0000, 6'h00, 2'd0, 5); collect(0);
        send(2'd0, 32'h0000_0020, 32'h0000_0000, 6'h0D, 2'd1, 5); collect(0);
        send(2'd0, 32'h0000_0030, 32'h0000_0030, 6'h06, 2'd2, 5); collect(0);
        send(2'd0, 32'h0000_0008, 32'h0000_0000, 6'h08, 2'd1, 5); collect(0);

        // 32-bit mode: codeword 8000_001F with bit 31 flipped is restored
        send(2'd2, 32'h0000_001F, 32'h8000_001F, 6'h3F, 2'd1, 7); collect(0);
        // Same codeword plus bit 20 in 8-bit mode: upper bits are dropped
        send(2'd0, 32'h8010_001F, 32'h0000_001B, 6'h0C, 2'd1, 5); collect(0);

        // 16-bit mode: clean word, then MSB error
        send(2'd1, 32'h0000_0000, 32'h0000_0000, 6'h00, 2'd0, 6); collect(0);
        send(2'd1, 32'h0000_8000, 32'h0000_0000, 6'h1F, 2'd1, 6); collect(0);

        // Consumer stall for 10 cycles with an ignored in_valid
        send(2'd0, 32'h0000_0020, 32'h0000_0000, 6'h0D, 2'd1, 5); collect(10);
        repeat (3) @(posedge clk);
        #1;
        check("ignored_word_no_output", 32'(out_valid), 32'd0);

        // Asynchronous reset during CALC discards the word
        send(2'd2, 32'h0000_001F, 32'h8000_001F, 6'h3F, 2'd1, 7);
        void'(sb.pop_front());
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_data_out", data_out, 32'd0);
        check("midrst_syndrome", 32'(syndrome), 32'd0);
        check("midrst_nerr", 32'(num_of_errors), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(2'd2, 32'h0000_001F, 32'h8000_001F, 6'h3F, 2'd1, 7); collect(0);

        // Illegal mode
        send(2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 6'h00, 2'd3, 1); collect(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
